// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Widths here are defaults; the top re-declares its entry type at its own parameter widths.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 32;
  localparam int PC_STEP     = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  addr;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with push/pop/flush and an occupancy count.
// Push and pop may coincide at any occupancy, including full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  entry_t           storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_data;
  end

  assign head  = storage[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: credit-gated instruction-memory reads, fixed-latency response tracker,
// and an instruction queue presented to decode over valid/ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int MEM_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_current,
  output logic               pc_enable,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               flush,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               ir_ready
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam int               SUM_W   = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [MEM_LAT-1:0] trk_valid;
  logic [ADDR_W-1:0]  trk_addr [MEM_LAT];
  logic [CNT_W-1:0]   occ;
  logic [CNT_W-1:0]   infl;
  logic [SUM_W-1:0]   credit_used;
  logic               issue;
  logic               push;
  logic               pop;
  logic               q_full;
  logic               q_empty;
  entry_t             push_entry;
  entry_t             head;

  // A slot is reserved at issue time, so a read is only sent when the queue can take its data.
  assign credit_used = {1'b0, occ} + {1'b0, infl};
  assign pop         = ir_valid & ir_ready;
  assign issue       = ~reset & ~flush &
                       ((credit_used < DEPTH_S) | ((credit_used == DEPTH_S) & pop));
  assign push        = trk_valid[MEM_LAT-1] & ~flush & ~reset;

  assign mem_rd    = issue;
  assign mem_addr  = pc_current;
  assign pc_enable = issue | (flush & ~reset);
  assign pc_plus4  = pc_current + ADDR_W'(PC_STEP);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      trk_valid <= '0;
      infl      <= '0;
    end else begin
      trk_valid[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) trk_valid[i] <= trk_valid[i-1];
      infl <= infl + {{(CNT_W-1){1'b0}}, issue} - {{(CNT_W-1){1'b0}}, push};
    end
  end

  always_ff @(posedge clk) begin
    trk_addr[0] <= pc_current;
    for (int i = 1; i < MEM_LAT; i++) trk_addr[i] <= trk_addr[i-1];
  end

  assign push_entry.addr  = trk_addr[MEM_LAT-1];
  assign push_entry.instr = mem_rdata;

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (occ)
  );

  assign ir_valid = ~q_empty;
  assign ir       = q_empty ? '0 : head.instr;
  assign ir_pc    = q_empty ? '0 : head.addr;

  a_infl_no_underflow: assert property (@(posedge clk) disable iff (reset) !(push && infl == '0));
  a_credit_bound:      assert property (@(posedge clk) disable iff (reset) credit_used <= DEPTH_S);
  a_no_push_full:      assert property (@(posedge clk) disable iff (reset) !(push && q_full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a MEM_LAT=1 and a MEM_LAT=3 instance share stimulus, each
// checked cycle by cycle against a queue-based model of fetch, return and decode.
module tb_instr_fetch_unit;

  localparam int NDUT  = 2;
  localparam int DEPTH = 4;

  typedef struct { logic [7:0] addr; logic [31:0] instr; } ent_t;
  typedef struct { logic [7:0] addr; int rem; } fly_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        ir_ready;
  logic [7:0]  br_target;
  logic        pc_force;
  logic [7:0]  pc_force_val;

  logic [7:0]  pc        [NDUT];
  logic        pc_enable [NDUT];
  logic [7:0]  pc_plus4  [NDUT];
  logic        mem_rd    [NDUT];
  logic [7:0]  mem_addr  [NDUT];
  logic [31:0] mem_rdata [NDUT];
  logic        ir_valid  [NDUT];
  logic [31:0] ir        [NDUT];
  logic [7:0]  ir_pc     [NDUT];

  logic [31:0] mem_tbl [64];
  logic [31:0] rd_pipe [NDUT][3];

  ent_t        mq     [NDUT][$];
  fly_t        mf     [NDUT][$];
  logic [7:0]  popped [NDUT][$];
  int          n_issue [NDUT];
  logic        last_rd [NDUT];
  logic        last_valid [NDUT];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(32), .MEM_LAT(1), .DEPTH(DEPTH)) u_dut_lat1 (
    .clk(clk), .reset(reset), .pc_current(pc[0]), .pc_enable(pc_enable[0]),
    .pc_plus4(pc_plus4[0]), .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]),
    .mem_rdata(mem_rdata[0]), .flush(flush), .ir_valid(ir_valid[0]), .ir(ir[0]),
    .ir_pc(ir_pc[0]), .ir_ready(ir_ready)
  );

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(32), .MEM_LAT(3), .DEPTH(DEPTH)) u_dut_lat3 (
    .clk(clk), .reset(reset), .pc_current(pc[1]), .pc_enable(pc_enable[1]),
    .pc_plus4(pc_plus4[1]), .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]),
    .mem_rdata(mem_rdata[1]), .flush(flush), .ir_valid(ir_valid[1]), .ir(ir[1]),
    .ir_pc(ir_pc[1]), .ir_ready(ir_ready)
  );

  always #5 clk = ~clk;

  // Environment: external PC register with branch mux, and fixed-latency instruction memory.
  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (pc_force)          pc[d] <= pc_force_val;
      else if (pc_enable[d]) pc[d] <= flush ? br_target : pc[d] + 8'd4;
      rd_pipe[d][0] <= mem_tbl[mem_addr[d][7:2]];
      rd_pipe[d][1] <= rd_pipe[d][0];
      rd_pipe[d][2] <= rd_pipe[d][1];
    end
  end
  assign mem_rdata[0] = rd_pipe[0][0];
  assign mem_rdata[1] = rd_pipe[1][2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // One clock: drive inputs, compare every output of both instances to the model, advance it.
  task automatic cycle(input logic rdy, input logic fl, input logic rst);
    @(negedge clk);
    ir_ready = rdy;
    flush    = fl;
    reset    = rst;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      int         occ;
      int         inf;
      logic       pop;
      logic       iss;
      logic [7:0] exp_p4;
      fly_t       f;
      occ    = mq[d].size();
      inf    = mf[d].size();
      pop    = (occ > 0) && rdy;
      iss    = !rst && !fl && ((occ + inf < DEPTH) || ((occ + inf == DEPTH) && pop));
      exp_p4 = pc[d] + 8'd4;

      checks++;
      if (mem_rd[d] !== iss) begin
        errors++;
        $display("FAIL d%0d cyc %0d mem_rd got %b exp %b", d, cyc, mem_rd[d], iss);
      end
      checks++;
      if (pc_enable[d] !== (iss || (fl && !rst))) begin
        errors++;
        $display("FAIL d%0d cyc %0d pc_enable got %b exp %b", d, cyc, pc_enable[d], iss || (fl && !rst));
      end
      checks++;
      if (pc_plus4[d] !== exp_p4) begin
        errors++;
        $display("FAIL d%0d cyc %0d pc_plus4 got %h exp %h", d, cyc, pc_plus4[d], exp_p4);
      end
      checks++;
      if (ir_valid[d] !== (occ > 0)) begin
        errors++;
        $display("FAIL d%0d cyc %0d ir_valid got %b exp %b", d, cyc, ir_valid[d], occ > 0);
      end
      if (occ > 0) begin
        checks++;
        if (ir[d] !== mq[d][0].instr || ir_pc[d] !== mq[d][0].addr) begin
          errors++;
          $display("FAIL d%0d cyc %0d head got %h@%h exp %h@%h", d, cyc, ir[d], ir_pc[d],
                   mq[d][0].instr, mq[d][0].addr);
        end
      end
      if (iss) begin
        checks++;
        if (mem_addr[d] !== pc[d]) begin
          errors++;
          $display("FAIL d%0d cyc %0d mem_addr got %h exp %h", d, cyc, mem_addr[d], pc[d]);
        end
      end

      last_rd[d]    = mem_rd[d];
      last_valid[d] = ir_valid[d];
      if (mem_rd[d] === 1'b1) n_issue[d]++;
      if (ir_valid[d] === 1'b1 && rdy) popped[d].push_back(ir_pc[d]);

      if (rst || fl) begin
        mq[d].delete();
        mf[d].delete();
      end else begin
        if (pop) void'(mq[d].pop_front());
        for (int i = 0; i < mf[d].size(); i++) begin
          f = mf[d][i];
          f.rem--;
          mf[d][i] = f;
        end
        while (mf[d].size() > 0 && mf[d][0].rem == 0) begin
          f = mf[d].pop_front();
          mq[d].push_back('{addr: f.addr, instr: mem_tbl[f.addr[7:2]]});
        end
        if (iss) mf[d].push_back('{addr: pc[d], rem: lat_of(d)});
      end
    end
    cyc++;
  endtask

  task automatic flush_to(input logic [7:0] target, input logic rdy);
    br_target = target;
    cycle(rdy, 1'b1, 1'b0);
    for (int d = 0; d < NDUT; d++) popped[d].delete();
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (ir_valid[d] !== 1'b0 || mem_rd[d] !== 1'b0 || pc_enable[d] !== 1'b0 ||
          ir[d] !== 32'h0 || ir_pc[d] !== 8'h00) begin
        errors++;
        $display("FAIL d%0d reset_state got v=%b rd=%b en=%b ir=%h pc=%h exp all zero",
                 d, ir_valid[d], mem_rd[d], pc_enable[d], ir[d], ir_pc[d]);
      end
    end
  endtask

  task automatic test_sequential();
    int first_rd [NDUT];
    int first_v  [NDUT];
    pc_force = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      first_rd[d] = -1;
      first_v[d]  = -1;
      popped[d].delete();
    end
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      for (int d = 0; d < NDUT; d++) begin
        if (first_rd[d] < 0 && last_rd[d] === 1'b1) first_rd[d] = k;
        if (first_v[d] < 0 && last_valid[d] === 1'b1) first_v[d] = k;
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (first_rd[d] != 0) begin
        errors++;
        $display("FAIL d%0d first_issue got cycle %0d exp 0", d, first_rd[d]);
      end
      checks++;
      if (first_v[d] - first_rd[d] != lat_of(d) + 1) begin
        errors++;
        $display("FAIL d%0d first_valid_latency got %0d exp %0d", d, first_v[d] - first_rd[d], lat_of(d) + 1);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (i >= popped[d].size() || popped[d][i] !== 8'(i * 4)) begin
          errors++;
          $display("FAIL d%0d seq_pc[%0d] got %h exp %h", d, i,
                   (i < popped[d].size()) ? popped[d][i] : 8'hxx, 8'(i * 4));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_pc;
    flush_to(8'h10, 1'b0);
    for (int d = 0; d < NDUT; d++) n_issue[d] = 0;
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (n_issue[d] != DEPTH) begin
        errors++;
        $display("FAIL d%0d stall_issues got %0d exp %0d", d, n_issue[d], DEPTH);
      end
      checks++;
      if (mem_rd[d] !== 1'b0 || pc_enable[d] !== 1'b0) begin
        errors++;
        $display("FAIL d%0d stall_quiet got rd=%b en=%b exp 0 0", d, mem_rd[d], pc_enable[d]);
      end
      popped[d].delete();
    end
    cycle(1'b1, 1'b0, 1'b0);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (last_valid[d] !== 1'b1 || last_rd[d] !== 1'b1) begin
        errors++;
        $display("FAIL d%0d release_restart got v=%b rd=%b exp 1 1", d, last_valid[d], last_rd[d]);
      end
    end
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0);
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_pc = 8'h10 + 8'(i * 4);
        checks++;
        if (i >= popped[d].size() || popped[d][i] !== exp_pc) begin
          errors++;
          $display("FAIL d%0d drain[%0d] got %h exp %h", d, i,
                   (i < popped[d].size()) ? popped[d][i] : 8'hxx, exp_pc);
        end
      end
    end
  endtask

  task automatic test_flush();
    int k;
    flush_to(8'h80, 1'b0);
    for (int j = 0; j < 4; j++) cycle(1'b0, 1'b0, 1'b0);
    br_target = 8'h40;
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (ir_valid[d] !== 1'b0) begin
        errors++;
        $display("FAIL d%0d post_flush_valid got %b exp 0", d, ir_valid[d]);
      end
      popped[d].delete();
    end
    k = 0;
    while ((popped[0].size() < 2 || popped[1].size() < 2) && k < 20) begin
      cycle(1'b1, 1'b0, 1'b0);
      k++;
    end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (popped[d].size() < 2) begin
        errors++;
        $display("FAIL d%0d flush_resume timeout got %0d pops exp 2", d, popped[d].size());
      end else if (popped[d][0] !== 8'h40 || popped[d][1] !== 8'h44) begin
        errors++;
        $display("FAIL d%0d flush_resume got %h,%h exp 40,44", d, popped[d][0], popped[d][1]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] wrap_exp [4];
    logic       seen [NDUT];
    wrap_exp = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    flush_to(8'hF8, 1'b1);
    for (int d = 0; d < NDUT; d++) seen[d] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      for (int d = 0; d < NDUT; d++) begin
        if (pc[d] === 8'hFC && !seen[d]) begin
          seen[d] = 1'b1;
          checks++;
          if (pc_plus4[d] !== 8'h00) begin
            errors++;
            $display("FAIL d%0d pc_plus4_wrap got %h exp 00", d, pc_plus4[d]);
          end
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (!seen[d]) begin
        errors++;
        $display("FAIL d%0d wrap_pc_seen got 0 exp 1", d);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (i >= popped[d].size() || popped[d][i] !== wrap_exp[i]) begin
          errors++;
          $display("FAIL d%0d wrap_seq[%0d] got %h exp %h", d, i,
                   (i < popped[d].size()) ? popped[d][i] : 8'hxx, wrap_exp[i]);
        end
      end
    end
  endtask

  task automatic test_toggle();
    int   k;
    logic rdy;
    flush_to(8'h00, 1'b0);
    rdy = 1'b1;
    k = 0;
    while ((popped[0].size() < 64 || popped[1].size() < 64) && k < 400) begin
      cycle(rdy, 1'b0, 1'b0);
      rdy = ~rdy;
      k++;
    end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (popped[d].size() < 64) begin
        errors++;
        $display("FAIL d%0d toggle timeout got %0d pops exp 64", d, popped[d].size());
      end else begin
        for (int i = 0; i < 64; i++) begin
          if (popped[d][i] !== 8'(i * 4)) begin
            errors++;
            $display("FAIL d%0d toggle_seq[%0d] got %h exp %h", d, i, popped[d][i], 8'(i * 4));
            break;
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic rdy;
    logic fl;
    for (int k = 0; k < 400; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      if (fl) br_target = 8'($urandom_range(0, 63) * 4);
      cycle(rdy, fl, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    flush_to(8'h20, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    pc_force     = 1'b1;
    pc_force_val = 8'h60;
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (ir_valid[d] !== 1'b0 || mem_rd[d] !== 1'b0 || pc_enable[d] !== 1'b0 ||
          ir[d] !== 32'h0 || ir_pc[d] !== 8'h00) begin
        errors++;
        $display("FAIL d%0d midreset_state got v=%b rd=%b en=%b ir=%h pc=%h exp all zero",
                 d, ir_valid[d], mem_rd[d], pc_enable[d], ir[d], ir_pc[d]);
      end
      popped[d].delete();
    end
    pc_force = 1'b0;
    k = 0;
    while ((popped[0].size() < 2 || popped[1].size() < 2) && k < 20) begin
      cycle(1'b1, 1'b0, 1'b0);
      k++;
    end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (popped[d].size() < 2) begin
        errors++;
        $display("FAIL d%0d after_reset timeout got %0d pops exp 2", d, popped[d].size());
      end else if (popped[d][0] !== 8'h60 || popped[d][1] !== 8'h64) begin
        errors++;
        $display("FAIL d%0d after_reset got %h,%h exp 60,64", d, popped[d][0], popped[d][1]);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    ir_ready     = 1'b0;
    br_target    = 8'h00;
    pc_force     = 1'b1;
    pc_force_val = 8'h00;
    for (int i = 0; i < 64; i++) mem_tbl[i] = $urandom;
    for (int d = 0; d < NDUT; d++) n_issue[d] = 0;

    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_wrap();
    test_toggle();
    test_random();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time limit exp finish");
    $fatal(1, "watchdog");
  end

endmodule
